// File: rtl/jtag_wr_sched.sv
//------------------------------------------------------------------------------
// Module      : jtag_wr_sched
// Description : Two-requester JTAG write scheduler. Round-robin arbitrates
//               write requests from two on-FPGA masters and sequences the DUT
//               TAP (trstn/tms/tdi) one TAP step per jtag_clk_i cycle: a
//               one-time TAP init (TRST, Test-Logic-Reset, IR load), then one
//               70-bit DR write frame per granted request. TDO of the last 32
//               shifted bits of each frame is captured and reported together
//               with a per-frame completion pulse.
// Ports       : jtag_clk_i / rst_n         clock, async active-low reset
//               req_valid_i / req_ready_o  per-requester handshake
//               req{0,1}_{addr,data}_i     write payloads
//               soft_init_i                request TAP re-init before next frame
//               tdo / trstn / tms / tdi    TAP pins
//               busy_o, done_o, done_id_o  frame status
//               tdo_word_o                 TDO captured in last frame
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module jtag_wr_sched #(
    parameter int                IR_LEN   = 4,
    parameter logic [IR_LEN-1:0] IR_VAL   = 4'h4,
    parameter logic [5:0]        CMD_WR   = 6'h20,
    parameter int                TRST_CYC = 2,
    parameter int                TLR_CYC  = 5
) (
    input  logic        jtag_clk_i,
    input  logic        rst_n,
    input  logic [1:0]  req_valid_i,
    output logic [1:0]  req_ready_o,
    input  logic [31:0] req0_addr_i,
    input  logic [31:0] req0_data_i,
    input  logic [31:0] req1_addr_i,
    input  logic [31:0] req1_data_i,
    input  logic        soft_init_i,
    input  logic        tdo,
    output logic        trstn,
    output logic        tms,
    output logic        tdi,
    output logic        busy_o,
    output logic        done_o,
    output logic        done_id_o,
    output logic [31:0] tdo_word_o
);

    localparam int         FRAME_LEN = 70;
    localparam logic [6:0] TDO_FIRST = 7'(FRAME_LEN - 32);

    // One state per TAP phase; the bit counter walks through each phase.
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_TRST     = 4'd1;  // trstn low
    localparam logic [3:0] S_TLR      = 4'd2;  // tms high -> Test-Logic-Reset
    localparam logic [3:0] S_IR_PRE   = 4'd3;  // tms 0,1,1,0,0: RTI .. Shift-IR
    localparam logic [3:0] S_SHIFT_IR = 4'd4;
    localparam logic [3:0] S_IR_POST  = 4'd5;  // tms 1,0: Update-IR, RTI
    localparam logic [3:0] S_DR_PRE   = 4'd6;  // tms 1,0,0: Sel-DR .. Shift-DR
    localparam logic [3:0] S_SHIFT_DR = 4'd7;
    localparam logic [3:0] S_DR_POST  = 4'd8;  // tms 1,0: Update-DR, RTI

    logic [3:0]           state;
    logic [3:0]           state_next;
    logic [6:0]           cnt;
    logic [6:0]           state_len;
    logic                 last;

    logic                 out_en;     // low only while in / just out of reset
    logic                 init_done;
    logic                 soft_pend;
    logic                 rr_ptr;     // 0 favours req0 when both are valid
    logic                 cur_id;
    logic [FRAME_LEN-1:0] frame_sh;
    logic [IR_LEN-1:0]    ir_sh;
    logic [31:0]          tdo_sh;

    logic                 both_valid;
    logic                 grant_id;
    logic                 accept;

    // Phase length and successor for the current state
    always_comb begin
        state_len  = 7'd1;
        state_next = S_IDLE;
        case (state)
            S_TRST:     begin state_len = 7'(TRST_CYC);  state_next = S_TLR;      end
            S_TLR:      begin state_len = 7'(TLR_CYC);   state_next = S_IR_PRE;   end
            S_IR_PRE:   begin state_len = 7'd5;          state_next = S_SHIFT_IR; end
            S_SHIFT_IR: begin state_len = 7'(IR_LEN);    state_next = S_IR_POST;  end
            S_IR_POST:  begin state_len = 7'd2;          state_next = S_DR_PRE;   end
            S_DR_PRE:   begin state_len = 7'd3;          state_next = S_SHIFT_DR; end
            S_SHIFT_DR: begin state_len = 7'(FRAME_LEN); state_next = S_DR_POST;  end
            S_DR_POST:  begin state_len = 7'd2;          state_next = S_IDLE;     end
            default:    begin state_len = 7'd1;          state_next = S_IDLE;     end
        endcase
    end

    assign last = (cnt == state_len - 7'd1);

    // Arbitration: the pointer only decides a tie; a lone requester always wins.
    assign both_valid  = &req_valid_i;
    assign grant_id    = both_valid ? rr_ptr : req_valid_i[1];
    assign accept      = out_en && (state == S_IDLE) && (|req_valid_i);
    assign req_ready_o = accept ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

    // TAP pin decode
    always_comb begin
        tms = 1'b0;
        tdi = 1'b0;
        case (state)
            S_TLR:      tms = 1'b1;
            S_IR_PRE:   tms = (cnt == 7'd1) || (cnt == 7'd2);
            S_SHIFT_IR: begin tms = last; tdi = ir_sh[0];    end
            S_IR_POST:  tms = (cnt == 7'd0);
            S_DR_PRE:   tms = (cnt == 7'd0);
            S_SHIFT_DR: begin tms = last; tdi = frame_sh[0]; end
            S_DR_POST:  tms = (cnt == 7'd0);
            default:    tms = 1'b0;
        endcase
    end

    // trstn is gated by out_en so it reads low during reset even though the
    // FSM already sits in IDLE.
    assign trstn  = out_en && (state != S_TRST);
    assign busy_o = (state != S_IDLE);

    always_ff @(posedge jtag_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= 7'd0;
            out_en     <= 1'b0;
            init_done  <= 1'b0;
            soft_pend  <= 1'b0;
            rr_ptr     <= 1'b0;
            cur_id     <= 1'b0;
            frame_sh   <= '0;
            ir_sh      <= '0;
            tdo_sh     <= '0;
            done_o     <= 1'b0;
            done_id_o  <= 1'b0;
            tdo_word_o <= '0;
        end else begin
            out_en <= 1'b1;
            done_o <= 1'b0;
            if (state == S_IDLE) begin
                if (accept) begin
                    cur_id   <= grant_id;
                    frame_sh <= grant_id ? {req1_data_i, req1_addr_i, CMD_WR}
                                         : {req0_data_i, req0_addr_i, CMD_WR};
                    ir_sh    <= IR_VAL;
                    if (both_valid) begin
                        rr_ptr <= ~grant_id;
                    end
                    state <= (!init_done || soft_pend || soft_init_i) ? S_TRST : S_DR_PRE;
                    cnt   <= 7'd0;
                end
            end else begin
                if (last) begin
                    state <= state_next;
                    cnt   <= 7'd0;
                end else begin
                    cnt <= cnt + 7'd1;
                end

                if (state == S_SHIFT_IR) begin
                    ir_sh <= ir_sh >> 1;
                end

                if (state == S_SHIFT_DR) begin
                    frame_sh <= frame_sh >> 1;
                    // Right shift lands the first captured bit in tdo_sh[0]
                    if (cnt >= TDO_FIRST) begin
                        tdo_sh <= {tdo, tdo_sh[31:1]};
                    end
                end

                if ((state == S_IR_POST) && last) begin
                    init_done <= 1'b1;
                    soft_pend <= 1'b0;
                end

                if ((state == S_DR_POST) && last) begin
                    done_o     <= 1'b1;
                    done_id_o  <= cur_id;
                    tdo_word_o <= tdo_sh;
                end
            end

            // Placed last so a request arriving as init completes is not lost
            if (soft_init_i) begin
                soft_pend <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_jtag_wr_sched.sv
//------------------------------------------------------------------------------
// Module      : tb_jtag_wr_sched
// Description : Directed self-checking bench for jtag_wr_sched. A behavioural
//               IEEE 1149.1 TAP model follows trstn/tms/tdi, records the IR
//               and DR values actually shifted, and drives tdo from a mask.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_jtag_wr_sched;

    logic        jtag_clk_i = 1'b0;
    logic        rst_n      = 1'b0;
    logic [1:0]  req_valid_i = 2'b00;
    logic [1:0]  req_ready_o;
    logic [31:0] req0_addr_i = '0, req0_data_i = '0;
    logic [31:0] req1_addr_i = '0, req1_data_i = '0;
    logic        soft_init_i = 1'b0;
    logic        tdo;
    logic        trstn, tms, tdi, busy_o, done_o, done_id_o;
    logic [31:0] tdo_word_o;

    int n_cmp = 0;
    int n_bad = 0;

    jtag_wr_sched dut (
        .jtag_clk_i (jtag_clk_i),
        .rst_n      (rst_n),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req0_addr_i(req0_addr_i),
        .req0_data_i(req0_data_i),
        .req1_addr_i(req1_addr_i),
        .req1_data_i(req1_data_i),
        .soft_init_i(soft_init_i),
        .tdo        (tdo),
        .trstn      (trstn),
        .tms        (tms),
        .tdi        (tdi),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .done_id_o  (done_id_o),
        .tdo_word_o (tdo_word_o)
    );

    always #5 jtag_clk_i = ~jtag_clk_i;

    // ---------------- TAP model ----------------
    localparam logic [3:0] T_TLR = 4'd0,  T_RTI = 4'd1,  T_SELDR = 4'd2,  T_CAPDR = 4'd3;
    localparam logic [3:0] T_SHDR = 4'd4, T_EX1DR = 4'd5, T_PAUDR = 4'd6, T_EX2DR = 4'd7;
    localparam logic [3:0] T_UPDR = 4'd8, T_SELIR = 4'd9, T_CAPIR = 4'd10, T_SHIR = 4'd11;
    localparam logic [3:0] T_EX1IR = 4'd12, T_PAUIR = 4'd13, T_EX2IR = 4'd14, T_UPIR = 4'd15;

    logic [3:0]  tap = T_TLR;
    logic [6:0]  dr_bits = '0, dr_bits_last = '0;
    logic [69:0] dr_sh = '0, dr_last = '0;
    logic [3:0]  ir_sh_m = '0, ir_reg = 4'hF;
    logic [69:0] tdo_mask = '0;

    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
        case (s)
            T_TLR:   return m ? T_TLR   : T_RTI;
            T_RTI:   return m ? T_SELDR : T_RTI;
            T_SELDR: return m ? T_SELIR : T_CAPDR;
            T_CAPDR: return m ? T_EX1DR : T_SHDR;
            T_SHDR:  return m ? T_EX1DR : T_SHDR;
            T_EX1DR: return m ? T_UPDR  : T_PAUDR;
            T_PAUDR: return m ? T_EX2DR : T_PAUDR;
            T_EX2DR: return m ? T_UPDR  : T_SHDR;
            T_UPDR:  return m ? T_SELDR : T_RTI;
            T_SELIR: return m ? T_TLR   : T_CAPIR;
            T_CAPIR: return m ? T_EX1IR : T_SHIR;
            T_SHIR:  return m ? T_EX1IR : T_SHIR;
            T_EX1IR: return m ? T_UPIR  : T_PAUIR;
            T_PAUIR: return m ? T_EX2IR : T_PAUIR;
            T_EX2IR: return m ? T_UPIR  : T_SHIR;
            default: return m ? T_SELDR : T_RTI;
        endcase
    endfunction

    assign tdo = (tap == T_SHDR && dr_bits < 7'd70) ? tdo_mask[dr_bits] : 1'b0;

    always @(posedge jtag_clk_i or negedge trstn) begin
        if (!trstn) begin
            tap    <= T_TLR;
            ir_reg <= 4'hF;
        end else begin
            tap <= tap_next(tap, tms);
            if (tap == T_TLR)   ir_reg  <= 4'hF;
            if (tap == T_CAPDR) dr_bits <= '0;
            if (tap == T_SHDR) begin
                dr_sh   <= {tdi, dr_sh[69:1]};
                dr_bits <= dr_bits + 7'd1;
            end
            if (tap == T_UPDR) begin
                dr_last      <= dr_sh;
                dr_bits_last <= dr_bits;
            end
            if (tap == T_SHIR) ir_sh_m <= {tdi, ir_sh_m[3:1]};
            if (tap == T_UPIR) ir_reg  <= ir_sh_m;
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    int           n, bcnt;
    logic [199:0] tms_v, trst_v, tdi_v;
    logic [1:0]   rdy;
    logic [74:0]  exp_tms_fr;

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid_i = 2'b00;
        repeat (2) @(posedge jtag_clk_i);
        @(negedge jtag_clk_i);
        rst_n = 1'b1;
    endtask

    // Presents a request at a negedge, samples ready, lets the accept edge pass.
    task automatic issue_req(input logic [1:0] v, input logic [31:0] a, input logic [31:0] d);
        @(negedge jtag_clk_i);
        req_valid_i = v;
        req0_addr_i = a; req0_data_i = d;
        req1_addr_i = a; req1_data_i = d;
        #1 rdy = req_ready_o;
        @(posedge jtag_clk_i);
        #1 req_valid_i = 2'b00;
    endtask

    // Records pins at every negedge after the accept edge until done_o.
    // n = index of the done cycle, -1 on timeout. soft_init pulsed at soft_cyc.
    task automatic capture(input int soft_cyc);
        n = -1; bcnt = 0; tms_v = '0; trst_v = '0; tdi_v = '0;
        for (int k = 0; k < 200 && n < 0; k++) begin
            @(negedge jtag_clk_i);
            soft_init_i = (k == soft_cyc);
            if (done_o) begin
                n = k;
            end else begin
                tms_v[k]  = tms;
                trst_v[k] = trstn;
                tdi_v[k]  = tdi;
                if (busy_o) bcnt++;
            end
        end
        soft_init_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        req_valid_i = 2'b01;
        #12;
        n_cmp++; if (trstn !== 1'b0) begin n_bad++; $display("FAIL rst_trstn: got %b want 0", trstn); end
        n_cmp++; if (tms !== 1'b0) begin n_bad++; $display("FAIL rst_tms: got %b want 0", tms); end
        n_cmp++; if (tdi !== 1'b0) begin n_bad++; $display("FAIL rst_tdi: got %b want 0", tdi); end
        n_cmp++; if (req_ready_o !== 2'b00) begin n_bad++; $display("FAIL rst_ready: got %b want 00", req_ready_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy_o); end
        n_cmp++; if (done_o !== 1'b0 || done_id_o !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b/%b want 0/0", done_o, done_id_o); end
        n_cmp++; if (tdo_word_o !== 32'h0) begin n_bad++; $display("FAIL rst_tdo_word: got %h want 0", tdo_word_o); end
        req_valid_i = 2'b00;
        @(negedge jtag_clk_i);
        rst_n = 1'b1;
        @(negedge jtag_clk_i);
        n_cmp++; if (trstn !== 1'b1 || tms !== 1'b0 || busy_o !== 1'b0) begin
            n_bad++; $display("FAIL idle_pins: got trstn=%b tms=%b busy=%b want 1 0 0", trstn, tms, busy_o);
        end
    endtask

    task automatic test_first_write();
        logic [69:0] fr;
        fr = {32'h0, 32'h1A107008, 6'h20};
        tdo_mask = '0; tdo_mask[38] = 1'b1; tdo_mask[69] = 1'b1;
        issue_req(2'b01, 32'h1A107008, 32'h0);
        n_cmp++; if (rdy !== 2'b01) begin n_bad++; $display("FAIL w1_ready: got %b want 01", rdy); end
        capture(-1);
        n_cmp++; if (n !== 93) begin n_bad++; $display("FAIL w1_latency: got %0d want 93", n); end
        n_cmp++; if (bcnt !== 93) begin n_bad++; $display("FAIL w1_busy_cycles: got %0d want 93", bcnt); end
        n_cmp++; if (trst_v[17:0] !== 18'h3FFFC) begin n_bad++; $display("FAIL w1_trstn_seq: got %h want 3fffc", trst_v[17:0]); end
        n_cmp++; if (tms_v[17:0] !== 18'h1837C) begin n_bad++; $display("FAIL w1_init_tms: got %h want 1837c", tms_v[17:0]); end
        n_cmp++; if (tdi_v[17:0] !== 18'h04000) begin n_bad++; $display("FAIL w1_ir_tdi: got %h want 04000", tdi_v[17:0]); end
        n_cmp++; if (tms_v[18 +: 75] !== exp_tms_fr) begin n_bad++; $display("FAIL w1_frame_tms: got %h want %h", tms_v[18 +: 75], exp_tms_fr); end
        n_cmp++; if (tdi_v[21 +: 70] !== fr) begin n_bad++; $display("FAIL w1_frame_tdi: got %h want %h", tdi_v[21 +: 70], fr); end
        n_cmp++; if (done_id_o !== 1'b0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL w1_done: got id=%b busy=%b want 0 0", done_id_o, busy_o); end
        n_cmp++; if (tdo_word_o !== 32'h80000001) begin n_bad++; $display("FAIL w1_tdo_word: got %h want 80000001", tdo_word_o); end
        n_cmp++; if (ir_reg !== 4'h4) begin n_bad++; $display("FAIL w1_tap_ir: got %h want 4", ir_reg); end
        n_cmp++; if (dr_last !== fr || dr_bits_last !== 7'd70) begin n_bad++; $display("FAIL w1_tap_dr: got %h/%0d want %h/70", dr_last, dr_bits_last, fr); end
        n_cmp++; if (tap !== T_RTI) begin n_bad++; $display("FAIL w1_tap_state: got %0d want %0d", tap, T_RTI); end
        @(negedge jtag_clk_i);
        n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL w1_done_pulse: got %b want 0", done_o); end
    endtask

    task automatic test_second_write();
        logic [69:0] fr;
        fr = {32'h12345678, 32'hDEADBEEF, 6'h20};
        tdo_mask = {32'h5A3C96E1, 38'h2A_AAAA_AAAA};
        issue_req(2'b10, 32'hDEADBEEF, 32'h12345678);
        n_cmp++; if (rdy !== 2'b10) begin n_bad++; $display("FAIL w2_ready: got %b want 10", rdy); end
        n_cmp++; if (tdo_word_o !== 32'h80000001) begin n_bad++; $display("FAIL w2_tdo_hold: got %h want 80000001", tdo_word_o); end
        capture(-1);
        n_cmp++; if (n !== 75) begin n_bad++; $display("FAIL w2_latency: got %0d want 75", n); end
        n_cmp++; if (trst_v[74:0] !== {75{1'b1}}) begin n_bad++; $display("FAIL w2_no_trst: got %h want all ones", trst_v[74:0]); end
        n_cmp++; if (tdi_v[8:3] !== 6'b100000) begin n_bad++; $display("FAIL w2_cmd_bits: got %b want 100000", tdi_v[8:3]); end
        n_cmp++; if (tms_v[74:0] !== exp_tms_fr) begin n_bad++; $display("FAIL w2_frame_tms: got %h want %h", tms_v[74:0], exp_tms_fr); end
        n_cmp++; if (dr_last !== fr) begin n_bad++; $display("FAIL w2_tap_dr: got %h want %h", dr_last, fr); end
        n_cmp++; if (done_id_o !== 1'b1) begin n_bad++; $display("FAIL w2_done_id: got %b want 1", done_id_o); end
        n_cmp++; if (tdo_word_o !== 32'h5A3C96E1) begin n_bad++; $display("FAIL w2_tdo_word: got %h want 5a3c96e1", tdo_word_o); end
    endtask

    task automatic test_soft_init();
        tdo_mask = '0;
        issue_req(2'b01, 32'h00000100, 32'hCAFEF00D);
        capture(30);
        n_cmp++; if (n !== 75) begin n_bad++; $display("FAIL si_inflight: got %0d want 75", n); end
        n_cmp++; if (dr_last !== {32'hCAFEF00D, 32'h00000100, 6'h20}) begin n_bad++; $display("FAIL si_frame: got %h", dr_last); end
        tdo_mask = {32'h0000FFFF, 38'h0};
        issue_req(2'b10, 32'h00000010, 32'h00000020);
        capture(-1);
        n_cmp++; if (n !== 93) begin n_bad++; $display("FAIL si_replay: got %0d want 93", n); end
        n_cmp++; if (trst_v[17:0] !== 18'h3FFFC) begin n_bad++; $display("FAIL si_trstn_seq: got %h want 3fffc", trst_v[17:0]); end
        n_cmp++; if (ir_reg !== 4'h4 || done_id_o !== 1'b1) begin n_bad++; $display("FAIL si_ir_id: got ir=%h id=%b want 4 1", ir_reg, done_id_o); end
        n_cmp++; if (tdo_word_o !== 32'h0000FFFF) begin n_bad++; $display("FAIL si_tdo_word: got %h want 0000ffff", tdo_word_o); end
    endtask

    task automatic test_reset_midframe();
        int dcnt;
        issue_req(2'b01, 32'h00000055, 32'h00000066);
        repeat (44) @(negedge jtag_clk_i);     // shift bit 40 on the pins
        rst_n = 1'b0;
        req_valid_i = 2'b01;
        #1;
        n_cmp++; if (trstn !== 1'b0 || tms !== 1'b0 || tdi !== 1'b0) begin n_bad++; $display("FAIL mr_pins: got %b%b%b want 000", trstn, tms, tdi); end
        n_cmp++; if (busy_o !== 1'b0 || done_o !== 1'b0 || req_ready_o !== 2'b00) begin n_bad++; $display("FAIL mr_status: got busy=%b done=%b rdy=%b", busy_o, done_o, req_ready_o); end
        n_cmp++; if (done_id_o !== 1'b0 || tdo_word_o !== 32'h0) begin n_bad++; $display("FAIL mr_regs: got id=%b word=%h want 0 0", done_id_o, tdo_word_o); end
        @(negedge jtag_clk_i);
        req_valid_i = 2'b00;
        rst_n = 1'b1;
        dcnt = 0;
        repeat (80) begin @(negedge jtag_clk_i); if (done_o) dcnt++; end
        n_cmp++; if (dcnt !== 0) begin n_bad++; $display("FAIL mr_no_done: got %0d pulses want 0", dcnt); end
        issue_req(2'b01, 32'h00000077, 32'h00000088);
        capture(-1);
        n_cmp++; if (n !== 93) begin n_bad++; $display("FAIL mr_reinit: got %0d want 93", n); end
        n_cmp++; if (trst_v[17:0] !== 18'h3FFFC || ir_reg !== 4'h4) begin n_bad++; $display("FAIL mr_init_seq: got trst=%h ir=%h", trst_v[17:0], ir_reg); end
        n_cmp++; if (dr_last !== {32'h00000088, 32'h00000077, 6'h20}) begin n_bad++; $display("FAIL mr_frame: got %h", dr_last); end
    endtask

    task automatic test_back_to_back();
        logic [69:0] fr0, fr1;
        logic        eid;
        fr0 = {32'h11111111, 32'hA0A00000, 6'h20};
        fr1 = {32'h22222222, 32'hB0B00000, 6'h20};
        do_reset();
        @(negedge jtag_clk_i);
        req0_addr_i = 32'hA0A00000; req0_data_i = 32'h11111111;
        req1_addr_i = 32'hB0B00000; req1_data_i = 32'h22222222;
        req_valid_i = 2'b11;
        #1;
        n_cmp++; if (req_ready_o !== 2'b01) begin n_bad++; $display("FAIL bb_first_grant: got %b want 01", req_ready_o); end
        for (int f = 0; f < 4; f++) begin
            eid = f[0];
            capture(-1);
            if (f == 3) req_valid_i = 2'b00;
            n_cmp++; if (n !== ((f == 0) ? 93 : 75)) begin n_bad++; $display("FAIL bb_latency%0d: got %0d want %0d", f, n, (f == 0) ? 93 : 75); end
            n_cmp++; if (done_id_o !== eid) begin n_bad++; $display("FAIL bb_id%0d: got %b want %b", f, done_id_o, eid); end
            n_cmp++; if (dr_last !== (eid ? fr1 : fr0)) begin n_bad++; $display("FAIL bb_frame%0d: got %h", f, dr_last); end
            if (f < 3) begin
                n_cmp++; if (req_ready_o !== (eid ? 2'b01 : 2'b10)) begin n_bad++; $display("FAIL bb_next_grant%0d: got %b want %b", f, req_ready_o, eid ? 2'b01 : 2'b10); end
            end
        end
    endtask

    initial begin
        exp_tms_fr = '0;
        exp_tms_fr[0]  = 1'b1;
        exp_tms_fr[72] = 1'b1;
        exp_tms_fr[73] = 1'b1;
        test_reset();
        test_first_write();
        test_second_write();
        test_soft_init();
        test_reset_midframe();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
